// File: rtl/onewire_pkg.sv
// Shared opcodes, sequencer state encoding and slot character selection
// for the byte-level 1-wire command sequencer.
package onewire_pkg;

  localparam logic [1:0] OP_RST = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_WR,
    S_WAIT,
    S_RD,
    S_RSP
  } state_t;

  // A read slot is a write-1 slot; the device pulls the line low to answer 0.
  function automatic logic [7:0] slot_char(input logic [1:0] op, input logic bit_val,
                                           input logic [7:0] rst_byte);
    case (op)
      OP_RST:  return rst_byte;
      OP_WR:   return bit_val ? 8'hFF : 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/onewire_seq_if.sv
// Command/response handshake plus the Avalon MM link to the UART onewire core.
// slave = the sequencer, master = its environment (host and core).
interface onewire_seq_if #(parameter int ADW = 32);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [7:0]     cmd_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [7:0]     rsp_data;
  logic           rsp_presence;
  logic           rsp_err;
  logic           avm_read;
  logic           avm_write;
  logic [ADW-1:0] avm_writedata;
  logic [ADW-1:0] avm_readdata;
  logic           avm_waitrequest;
  logic           avm_interrupt;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  avm_readdata, avm_waitrequest, avm_interrupt,
    output cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_err,
    output avm_read, avm_write, avm_writedata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    output avm_readdata, avm_waitrequest, avm_interrupt,
    input  cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_err,
    input  avm_read, avm_write, avm_writedata
  );
endinterface

// File: rtl/onewire_seq.sv
// Byte-level 1-wire sequencer: one UART character per time slot to the onewire
// core, echoed characters folded into a response byte with presence/error flags.
module onewire_seq
  import onewire_pkg::*;
#(
  parameter int         ADW      = 32,
  parameter int         BYTESIZE = 8,
  parameter logic [7:0] RST_BYTE = 8'hF0,
  parameter int         TIMEOUT  = 1024,
  parameter int         TO_LOG   = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  onewire_seq_if.slave  bus
);

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [7:0]          tx_q, tx_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [TO_LOG-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]          data_q, data_d;
  logic                pres_q, pres_d;
  logic                err_q, err_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                avm_read_q, avm_read_d;
  logic                avm_write_q, avm_write_d;
  logic [ADW-1:0]      wdata_q, wdata_d;
  logic [7:0]          rd_byte;
  logic                rd_bit;

  assign rd_byte = bus.avm_readdata[7:0];
  assign rd_bit  = (rd_byte == 8'hFF);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tx_d      = tx_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    data_d    = data_q;
    pres_d    = pres_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d      = bus.cmd_op;
          tx_d      = bus.cmd_data;
          bit_cnt_d = (bus.cmd_op == OP_RST) ? 3'd0 : 3'd7;
          data_d    = 8'h00;
          pres_d    = 1'b0;
          err_d     = 1'b0;
          if (bus.cmd_op == OP_RSV) begin
            err_d   = 1'b1;
            state_d = S_RSP;
          end else if (bus.avm_interrupt) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_FLUSH: state_d = S_WR;
      S_WR: begin
        if (!bus.avm_waitrequest) begin
          to_cnt_d = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.avm_interrupt) begin
          state_d = S_RD;
        end else begin
          to_cnt_d = to_cnt_q + TO_LOG'(1);
          if (to_cnt_d == TO_LOG'(TIMEOUT)) begin
            // Align the bits sampled so far to the LSB; unsampled bits read as 0.
            data_d  = data_q >> ({1'b0, bit_cnt_q} + 4'd1);
            err_d   = 1'b1;
            state_d = S_RSP;
          end
        end
      end
      S_RD: begin
        err_d = err_q | bus.avm_readdata[ADW-2];
        if (op_q == OP_RST) pres_d = (rd_byte != RST_BYTE);
        else                data_d = {rd_bit, data_q[7:1]};
        if (bit_cnt_q == 3'd0) begin
          state_d = S_RSP;
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
          tx_d      = tx_q >> 1;
          state_d   = S_WR;
        end
      end
      S_RSP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RSP);
    avm_write_d = (state_d == S_WR);
    avm_read_d  = (state_d == S_FLUSH) || (state_d == S_RD);
    wdata_d     = (state_d == S_WR) ?
                  ADW'(BYTESIZE'(slot_char(op_d, tx_d[0], RST_BYTE))) : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_RST;
      tx_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      to_cnt_q    <= '0;
      data_q      <= 8'h00;
      pres_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      avm_read_q  <= 1'b0;
      avm_write_q <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      tx_q        <= tx_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      data_q      <= data_d;
      pres_q      <= pres_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      avm_read_q  <= avm_read_d;
      avm_write_q <= avm_write_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = data_q;
  assign bus.rsp_presence  = pres_q;
  assign bus.rsp_err       = err_q;
  assign bus.avm_read      = avm_read_q;
  assign bus.avm_write     = avm_write_q;
  assign bus.avm_writedata = wdata_q;

  // The core's rdy flag and upper status bits carry nothing the sequencer needs.
  logic unused_rd;
  assign unused_rd = ^{bus.avm_readdata[ADW-1], bus.avm_readdata[ADW-3:8]};

endmodule

// File: tb/tb_onewire_seq.sv
// Bench for onewire_seq: behavioural onewire core model plus a per-command
// reference that predicts the bus transaction log and the response byte.
module tb_onewire_seq;
  import onewire_pkg::*;

  localparam int         ADW  = 32;
  localparam int         TO   = 24;
  localparam logic [7:0] RSTB = 8'hF0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  onewire_seq_if #(.ADW(ADW)) ifc();

  onewire_seq #(.ADW(ADW), .BYTESIZE(8), .RST_BYTE(RSTB), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // stimulus configuration (written by the directed sequence only)
  logic [7:0] cfg_slave     = 8'hFF;
  bit         cfg_pres      = 1'b0;
  int         cfg_err_slot  = -1;
  int         cfg_drop_slot = -1;
  int         cfg_stall     = 0;
  int         cfg_dly_max   = 6;
  int         stale_req_cnt = 0;

  // core model state (written by the model process only)
  logic           intr  = 1'b0;
  logic           wreq  = 1'b0;
  logic [ADW-1:0] rdata = '0;
  int             cd = 0, slot = 0, stall_left = 0, stale_done = 0;
  bit             pend_err = 1'b0, hold_prev = 1'b0;
  logic [7:0]     pend_echo = 8'h00;
  logic [31:0]    prev_wd = '0;
  logic [8:0]     log_q[$];

  assign ifc.avm_interrupt   = intr;
  assign ifc.avm_waitrequest = wreq;
  assign ifc.avm_readdata    = rdata;

  // Onewire core: pre-edge values are the transfer that happens at this edge.
  always @(posedge clk) begin
    bit wf, rf, ac, rs;
    logic [31:0] wd;
    wf = ifc.avm_write && !ifc.avm_waitrequest;
    rf = ifc.avm_read;
    ac = ifc.cmd_valid && ifc.cmd_ready;
    rs = rst;
    wd = ifc.avm_writedata;
    if (rs) begin
      chk("rw_exclusive", {31'b0, ifc.avm_read & ifc.avm_write}, 32'd0);
      if (hold_prev) begin
        chk("wr_hold_write", {31'b0, ifc.avm_write}, 32'd1);
        chk("wr_hold_data", wd, prev_wd);
      end
    end
    hold_prev = rs && ifc.avm_write && ifc.avm_waitrequest;
    prev_wd   = wd;
    #1;
    if (!rs) begin
      intr = 1'b0; wreq = 1'b0; rdata = '0; cd = 0; stall_left = 0;
      hold_prev = 1'b0;
      log_q.delete();
    end else begin
      if (ac) begin
        slot = 0;
        log_q.delete();
        stall_left = cfg_stall;
      end
      if (rf) begin
        log_q.push_back(9'h100);
        intr  = 1'b0;
        rdata = '0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          intr  = 1'b1;
          rdata = {1'b1, pend_err, 22'b0, pend_echo};
        end
      end
      if (wf) begin
        chk("wdata_upper_zero", {8'b0, wd[31:8]}, 32'd0);
        log_q.push_back({1'b0, wd[7:0]});
        if (wd[7:0] == RSTB)       pend_echo = cfg_pres ? 8'hE0 : RSTB;
        else if (wd[7:0] == 8'hFF) pend_echo = cfg_slave[slot[2:0]] ? 8'hFF
                                                : 8'(8'hFF << $urandom_range(4, 1));
        else                       pend_echo = 8'h00;
        pend_err = (slot == cfg_err_slot);
        if (slot != cfg_drop_slot) cd = $urandom_range(cfg_dly_max, 2);
        slot++;
      end
      if (stale_req_cnt != stale_done) begin
        stale_done = stale_req_cnt;
        intr  = 1'b1;
        rdata = {2'b11, 22'b0, 8'h5A};
      end
      wreq = 1'b0;
      if (ifc.avm_write && stall_left > 0) begin
        wreq = 1'b1;
        stall_left--;
      end
    end
  end

  function automatic int nwrites();
    int n = 0;
    foreach (log_q[i]) if (!log_q[i][8]) n++;
    return n;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    int n = 0;
    while (!ifc.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_idle", {31'b0, ifc.cmd_ready}, 32'd1);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_data  = d;
    @(posedge clk);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 2'($urandom);
    ifc.cmd_data  = 8'($urandom);
  endtask

  // mode 0: plain, 1: check exact timeout latency, 2: check immediate response
  task automatic run(input logic [1:0] op, input logic [7:0] d, input logic [7:0] slave,
                     input bit pres, input int err_slot, input int drop, input int stall,
                     input bit stale, input int hold, input int mode);
    logic [8:0] exp_log[$];
    logic [7:0] ed = 8'h00, ch;
    bit         ee = 1'b0, ep = 1'b0;
    int         ns, last, n, fires;
    cfg_slave = slave; cfg_pres = pres; cfg_err_slot = err_slot;
    cfg_drop_slot = drop; cfg_stall = stall;
    if (stale) begin
      stale_req_cnt++;
      @(negedge clk);
      exp_log.push_back(9'h100);
    end
    if (op == OP_RSV) begin
      ee = 1'b1;
    end else begin
      ns   = (op == OP_RST) ? 1 : 8;
      last = (drop >= 0 && drop < ns) ? drop : ns - 1;
      for (int s = 0; s <= last; s++) begin
        ch = (op == OP_RST) ? RSTB : ((op == OP_RD || d[s]) ? 8'hFF : 8'h00);
        exp_log.push_back({1'b0, ch});
        if (s == drop) begin
          ee = 1'b1;
        end else begin
          exp_log.push_back(9'h100);
          if (op != OP_RST) ed[s] = (ch == 8'hFF) && slave[s];
          else              ep = pres;
          if (s == err_slot) ee = 1'b1;
        end
      end
    end

    issue(op, d);
    if (mode == 2) chk("rsv_rsp_immediate", {31'b0, ifc.rsp_valid}, 32'd1);
    if (mode == 1) begin
      fires = 0;
      n = 0;
      while (n < 2000) begin
        if (ifc.avm_write && !ifc.avm_waitrequest) fires++;
        if (fires == drop + 1) break;
        @(negedge clk);
        n++;
      end
      chk("to_slot_reached", fires, drop + 1);
      repeat (TO) @(negedge clk);
      chk("to_not_early", {31'b0, ifc.rsp_valid}, 32'd0);
      @(negedge clk);
      chk("to_exact", {31'b0, ifc.rsp_valid}, 32'd1);
    end
    n = 0;
    while (!ifc.rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_within_bound", {31'b0, ifc.rsp_valid}, 32'd1);
    chk("rsp_data", {24'b0, ifc.rsp_data}, {24'b0, ed});
    chk("rsp_presence", {31'b0, ifc.rsp_presence}, {31'b0, ep});
    chk("rsp_err", {31'b0, ifc.rsp_err}, {31'b0, ee});
    chk("cmd_ready_busy", {31'b0, ifc.cmd_ready}, 32'd0);
    chk("log_len", log_q.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
      chk("log_entry", {23'b0, log_q[i]}, {23'b0, exp_log[i]});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold_valid", {31'b0, ifc.rsp_valid}, 32'd1);
      chk("rsp_hold_data", {24'b0, ifc.rsp_data}, {24'b0, ed});
      chk("rsp_hold_err", {31'b0, ifc.rsp_err}, {31'b0, ee});
      chk("rsp_hold_ready_low", {31'b0, ifc.cmd_ready}, 32'd0);
    end
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
    chk("rsp_released", {31'b0, ifc.rsp_valid}, 32'd0);
    chk("cmd_ready_back", {31'b0, ifc.cmd_ready}, 32'd1);
  endtask

  initial begin
    int n, er, dr;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 2'b00;
    ifc.cmd_data  = 8'h00;
    ifc.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_avm_read", {31'b0, ifc.avm_read}, 32'd0);
    chk("rst_avm_write", {31'b0, ifc.avm_write}, 32'd0);
    chk("rst_writedata", ifc.avm_writedata, 32'd0);
    chk("rst_rsp_valid", {31'b0, ifc.rsp_valid}, 32'd0);
    chk("rst_rsp_fields", {22'b0, ifc.rsp_data, ifc.rsp_presence, ifc.rsp_err}, 32'd0);
    chk("rst_cmd_ready", {31'b0, ifc.cmd_ready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);

    run(OP_RST, 8'h00, 8'hFF, 1'b1, -1, -1, 0, 1'b0, 0, 0);
    run(OP_RST, 8'h00, 8'hFF, 1'b0, -1, -1, 0, 1'b0, 0, 0);
    run(OP_WR,  8'hA5, 8'hFF, 1'b0, -1, -1, 0, 1'b0, 0, 0);
    run(OP_RD,  8'h00, 8'h3C, 1'b0, -1, -1, 0, 1'b0, 0, 0);
    run(OP_WR,  8'h5A, 8'hFF, 1'b0, -1,  0, 0, 1'b0, 0, 1);
    run(OP_WR,  8'hC3, 8'hFF, 1'b0, -1, -1, 5, 1'b1, 10, 0);

    // synchronous reset while the fifth slot of a WRITE is in flight
    cfg_drop_slot = -1; cfg_err_slot = -1; cfg_stall = 0; cfg_slave = 8'hFF;
    issue(OP_WR, 8'h96);
    n = 0;
    while (nwrites() < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reset_slot4", nwrites(), 5);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_avm", {30'b0, ifc.avm_read, ifc.avm_write}, 32'd0);
    chk("mid_reset_wdata", ifc.avm_writedata, 32'd0);
    chk("mid_reset_rsp_valid", {31'b0, ifc.rsp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    run(OP_WR, 8'h69, 8'hFF, 1'b0, -1, -1, 0, 1'b0, 0, 0);

    run(OP_RSV, 8'h77, 8'hFF, 1'b0, -1, -1, 0, 1'b0, 0, 2);
    run(OP_RD,  8'h00, 8'hB6, 1'b0,  3, -1, 0, 1'b0, 0, 0);
    run(OP_RD,  8'h00, 8'hFF, 1'b0, -1,  5, 2, 1'b0, 0, 1);

    for (int k = 0; k < 14; k++) begin
      er = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
      dr = ($urandom_range(4, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
      cfg_dly_max = $urandom_range(10, 2);
      run(2'($urandom_range(2, 0)), 8'($urandom), 8'($urandom), 1'($urandom),
          er, dr, $urandom_range(3, 0), ($urandom_range(3, 0) == 0),
          $urandom_range(3, 0), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
